// File: rtl/bcd_counter_chain.sv
// Presettable DIGITS-digit decade counter, up/down, 8421 or 5421 I/O coding, tc for cascading.
// One-edge latency for load/count; no backpressure, sustains one count per clk while en is high.
module bcd_counter_chain #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                load,
  input  logic                en,
  input  logic                up,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] d,
  output logic [4*DIGITS-1:0] q,
  output logic                tc,
  output logic                err
);

  logic [DIGITS-1:0][3:0] val;
  logic [DIGITS-1:0][3:0] cnt_val;
  logic [DIGITS-1:0][3:0] ld_val;
  logic [DIGITS-1:0]      ld_bad;
  logic                   all_term;

  function automatic logic code_bad(input logic [3:0] c, input logic m);
    return m ? (c[2:0] > 3'd4) : (c > 4'd9);
  endfunction

  // 5421: bit 3 carries weight 5, the low three bits are 0..4
  function automatic logic [3:0] decode(input logic [3:0] c, input logic m);
    if (code_bad(c, m)) return 4'd0;
    if (m && c[3]) return {1'b0, c[2:0]} + 4'd5;
    if (m) return {1'b0, c[2:0]};
    return c;
  endfunction

  function automatic logic [3:0] encode(input logic [3:0] v, input logic m);
    if (m && (v > 4'd4)) return v + 4'd3;
    return v;
  endfunction

  always_comb begin
    logic roll;
    roll = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ld_bad[i] = code_bad(d[4*i +: 4], mode);
      ld_val[i] = decode(d[4*i +: 4], mode);
      q[4*i +: 4] = encode(val[i], mode);
      // a digit steps only when every lower digit sits at its terminal value
      if (!roll)
        cnt_val[i] = val[i];
      else if (up)
        cnt_val[i] = (val[i] == 4'd9) ? 4'd0 : val[i] + 4'd1;
      else
        cnt_val[i] = (val[i] == 4'd0) ? 4'd9 : val[i] - 4'd1;
      roll = roll & (up ? (val[i] == 4'd9) : (val[i] == 4'd0));
    end
    all_term = roll;
  end

  assign tc = clr & en & load & all_term;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      val <= '0;
      err <= 1'b0;
    end else if (!load) begin
      val <= ld_val;
      err <= |ld_bad;
    end else if (en) begin
      val <= cnt_val;
    end
  end

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Bench for bcd_counter_chain: a 2-digit instance plus two cascaded 1-digit instances, checked against a decimal model.
module tb_bcd_counter_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr = 1'b0, load = 1'b1, en = 1'b0, up = 1'b1, mode = 1'b0;
  logic [7:0] d = 8'h00;
  logic [7:0] q;
  logic       tc, err;
  logic [3:0] q0, q1;
  logic       tc0, tc1, err0, err1;

  bcd_counter_chain #(.DIGITS(2)) dut (
    .clk(clk), .clr(clr), .load(load), .en(en), .up(up), .mode(mode),
    .d(d), .q(q), .tc(tc), .err(err)
  );

  bcd_counter_chain #(.DIGITS(1)) c0 (
    .clk(clk), .clr(clr), .load(load), .en(en), .up(up), .mode(mode),
    .d(d[3:0]), .q(q0), .tc(tc0), .err(err0)
  );

  bcd_counter_chain #(.DIGITS(1)) c1 (
    .clk(clk), .clr(clr), .load(load), .en(tc0), .up(up), .mode(mode),
    .d(d[7:4]), .q(q1), .tc(tc1), .err(err1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Decimal model: digit value from a code, -1 when the code is illegal in that mode
  function automatic int dig(input logic [3:0] c, input logic m);
    int lo;
    lo = int'(c[2:0]);
    if (m) begin
      if (lo > 4) return -1;
      return (c[3] ? 5 : 0) + lo;
    end
    if (int'(c) > 9) return -1;
    return int'(c);
  endfunction

  function automatic logic [3:0] enc_dig(input int v, input logic m);
    if (m && v >= 5) return 4'(8 + v - 5);
    return 4'(v);
  endfunction

  function automatic logic [7:0] enc(input int n, input logic m);
    logic [3:0] hi, lo;
    hi = enc_dig(n / 10, m);
    lo = enc_dig(n % 10, m);
    return {hi, lo};
  endfunction

  int mcnt = 0;
  bit merr = 1'b0;
  int da, db;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      mcnt = 0;
      merr = 1'b0;
    end else if (!load) begin
      da   = dig(d[3:0], mode);
      db   = dig(d[7:4], mode);
      merr = (da < 0) || (db < 0);
      mcnt = (da < 0 ? 0 : da) + 10 * (db < 0 ? 0 : db);
    end else if (en) begin
      mcnt = up ? (mcnt + 1) % 100 : (mcnt + 99) % 100;
    end
  end

  logic [7:0] exp_q;
  logic       exp_tc;

  always @(negedge clk) begin
    exp_q  = enc(mcnt, mode);
    exp_tc = clr & en & load & (up ? (mcnt == 99) : (mcnt == 0));
    chk("mdl_q", q, exp_q);
    chk("mdl_tc", tc, exp_tc);
    chk("mdl_err", err, merr);
    chk("casc_q", {q1, q0}, exp_q);
    chk("casc_tc", tc1, exp_tc);
    chk("casc_err", err0 | err1, merr);
  end

  task automatic nx();
    @(negedge clk);
    #2;
  endtask

  logic [7:0] s2q [5] = '{8'h97, 8'h98, 8'h99, 8'h00, 8'h01};
  logic       s2t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] s3q [4] = '{8'h01, 8'h00, 8'h99, 8'h98};
  logic       s3t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] s4q [4] = '{8'h0B, 8'h0C, 8'h10, 8'h11};

  initial begin
    // reset held with random inputs
    repeat (4) begin
      load = 1'($urandom); en = 1'($urandom); up = 1'($urandom);
      mode = 1'($urandom); d = 8'($urandom);
      nx();
      chk("rst_q", q, 8'h00); chk("rst_tc", tc, 1'b0); chk("rst_err", err, 1'b0);
    end
    clr = 1'b1; load = 1'b1; en = 1'b0; up = 1'b1; mode = 1'b0;
    repeat (3) begin
      nx();
      chk("idle_q", q, 8'h00); chk("idle_tc", tc, 1'b0); chk("idle_err", err, 1'b0);
    end

    // BCD count up through 99 -> 00
    load = 1'b0; d = 8'h97; nx();
    load = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("up_q", q, s2q[i]); chk("up_tc", tc, s2t[i]);
      if (i < 4) nx();
    end

    // BCD count down through 00 -> 99
    en = 1'b0; load = 1'b0; d = 8'h01; nx();
    load = 1'b1; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("dn_q", q, s3q[i]); chk("dn_tc", tc, s3t[i]);
      if (i < 3) nx();
    end

    // 5421 count up, then reinterpret as BCD without an edge
    en = 1'b0; mode = 1'b1; load = 1'b0; d = 8'h0B; nx();
    load = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bq_q", q, s4q[i]);
      if (i < 3) nx();
    end
    en = 1'b0; mode = 1'b0; #1;
    chk("bq_to_bcd_q", q, 8'h11);

    // BCD-legal but 5421-illegal low digit
    mode = 1'b1; load = 1'b0; d = 8'h97; nx();
    load = 1'b1;
    chk("bq_bad_q", q, 8'h90); chk("bq_bad_err", err, 1'b1);
    load = 1'b0; d = 8'h00; nx();
    load = 1'b1;
    chk("bq_ok_err", err, 1'b0);

    // invalid BCD preset, sticky err over counting, cleared by a valid load
    mode = 1'b0; load = 1'b0; d = 8'h3C; nx();
    load = 1'b1;
    chk("inv_q", q, 8'h30); chk("inv_err", err, 1'b1);
    en = 1'b1; up = 1'b1;
    repeat (5) nx();
    chk("inv_cnt_q", q, 8'h35); chk("inv_sticky_err", err, 1'b1);
    en = 1'b0; load = 1'b0; d = 8'h42; nx();
    load = 1'b1;
    chk("ok_q", q, 8'h42); chk("ok_err", err, 1'b0);

    // short asynchronous clear pulse mid-cycle
    load = 1'b0; d = 8'hA5; nx();
    load = 1'b1;
    chk("pre_clr_q", q, 8'h05); chk("pre_clr_err", err, 1'b1);
    @(negedge clk);
    #1 clr = 1'b0;
    #1;
    chk("aclr_q", q, 8'h00); chk("aclr_err", err, 1'b0);
    #1 clr = 1'b1;
    nx();
    chk("post_clr_q", q, 8'h00);

    // cascade of two single-digit stages against the 2-digit instance
    load = 1'b0; d = 8'h00; mode = 1'b0; nx();
    load = 1'b1; en = 1'b1; up = 1'b1;
    repeat (25) nx();
    chk("chain_q", q, 8'h25); chk("chain_casc_q", {q1, q0}, 8'h25);
    en = 1'b0;
    nx();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
